// File: rtl/por_release_sequencer.sv
// Power-on reset release sequencer: synchronizes and filters the level-shifted power-good input,
// then releases porb_l, rstb_core and rstb_user in a fixed staged order.
module por_release_sequencer #(
   parameter int unsigned FILTER_CYCLES = 16,
   parameter int unsigned STAGE_DELAY   = 8,
   parameter int unsigned ACK_TIMEOUT   = 200
) (
   input  logic       clock,
   input  logic       resetb,
   input  logic       por_yl,
   input  logic       cfg_done,
   output logic       porb_l,
   output logic       rstb_core,
   output logic       rstb_user,
   output logic       por_fault,
   output logic [2:0] seq_state
);

   typedef enum logic [2:0] {
      StHold    = 3'd0,
      StFilter  = 3'd1,
      StCoreRel = 3'd2,
      StWaitAck = 3'd3,
      StRun     = 3'd4
   } state_e;

   localparam logic [7:0] FilterLast = 8'(FILTER_CYCLES - 1);
   localparam logic [7:0] StageLast  = 8'(STAGE_DELAY - 1);
   localparam logic [7:0] AckLast    = 8'(ACK_TIMEOUT - 1);

   state_e     state, state_nxt;
   logic [7:0] cnt, cnt_nxt;
   logic       sync1, sync2;
   logic       fault_nxt;

   assign seq_state = state;

   // A low synchronized power-good beats every other transition once filtering has begun.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      fault_nxt = por_fault;
      case (state)
         StHold: begin
            cnt_nxt = '0;
            if (sync2) begin
               state_nxt = StFilter;
               cnt_nxt   = 8'd1;
            end
         end
         StFilter: begin
            if (!sync2) begin
               state_nxt = StHold;
               cnt_nxt   = '0;
            end else if (cnt == FilterLast) begin
               state_nxt = StCoreRel;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 8'd1;
            end
         end
         StCoreRel: begin
            if (!sync2) begin
               state_nxt = StHold;
               cnt_nxt   = '0;
            end else if (cnt == StageLast) begin
               state_nxt = StWaitAck;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 8'd1;
            end
         end
         StWaitAck: begin
            if (!sync2) begin
               state_nxt = StHold;
               cnt_nxt   = '0;
            end else if (cfg_done) begin
               state_nxt = StRun;
               cnt_nxt   = '0;
            end else if (cnt == AckLast) begin
               state_nxt = StRun;
               cnt_nxt   = '0;
               fault_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt + 8'd1;
            end
         end
         StRun: begin
            cnt_nxt = '0;
            if (!sync2) begin
               state_nxt = StHold;
            end
         end
         default: begin
            state_nxt = StHold;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Outputs decode the next state so they change on the same edge as the state register.
   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         sync1     <= 1'b0;
         sync2     <= 1'b0;
         state     <= StHold;
         cnt       <= '0;
         por_fault <= 1'b0;
         porb_l    <= 1'b0;
         rstb_core <= 1'b0;
         rstb_user <= 1'b0;
      end else begin
         sync1     <= por_yl;
         sync2     <= sync1;
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         por_fault <= fault_nxt;
         porb_l    <= (state_nxt == StCoreRel) || (state_nxt == StWaitAck) || (state_nxt == StRun);
         rstb_core <= (state_nxt == StWaitAck) || (state_nxt == StRun);
         rstb_user <= (state_nxt == StRun);
      end
   end

endmodule

// File: tb/tb_por_release_sequencer.sv
// Bench for por_release_sequencer: run-length power-good model checked every cycle, plus directed
// latency, glitch, timeout, brownout, priority and async-reset scenarios.
module tb_por_release_sequencer;

   localparam int FC = 16;
   localparam int SD = 8;
   localparam int AT = 200;

   logic       clock = 1'b0;
   logic       resetb = 1'b0;
   logic       por_yl = 1'b0;
   logic       cfg_done = 1'b0;
   logic       porb_l, rstb_core, rstb_user, por_fault;
   logic [2:0] seq_state;

   int tests = 0;
   int fails = 0;

   por_release_sequencer #(
      .FILTER_CYCLES(FC),
      .STAGE_DELAY  (SD),
      .ACK_TIMEOUT  (AT)
   ) dut (
      .clock    (clock),
      .resetb   (resetb),
      .por_yl   (por_yl),
      .cfg_done (cfg_done),
      .porb_l   (porb_l),
      .rstb_core(rstb_core),
      .rstb_user(rstb_user),
      .por_fault(por_fault),
      .seq_state(seq_state)
   );

   initial forever #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input int exp);
      tests++;
      if (act !== 32'(exp)) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: outputs follow from how many consecutive edges have seen synchronized power good.
   int   hi_run = 0;
   bit   user_rel = 1'b0;
   bit   fault_m = 1'b0;
   logic yl_d1 = 1'b0;
   logic yl_d2 = 1'b0;

   initial begin
      logic ps;
      forever begin
         @(posedge clock or negedge resetb);
         if (!resetb) begin
            yl_d1 = 1'b0; yl_d2 = 1'b0; hi_run = 0; user_rel = 1'b0; fault_m = 1'b0;
         end else begin
            ps    = yl_d2;
            yl_d2 = yl_d1;
            yl_d1 = por_yl;
            if (!ps) begin
               hi_run   = 0;
               user_rel = 1'b0;
            end else begin
               if (hi_run < 1000000) hi_run++;
               if (!user_rel && hi_run > FC + SD) begin
                  if (cfg_done) user_rel = 1'b1;
                  else if (hi_run == FC + SD + AT) begin
                     user_rel = 1'b1;
                     fault_m  = 1'b1;
                  end
               end
            end
         end
      end
   end

   function automatic int exp_state();
      if (hi_run == 0) return 0;
      if (hi_run < FC) return 1;
      if (hi_run < FC + SD) return 2;
      if (!user_rel) return 3;
      return 4;
   endfunction

   initial forever begin
      @(negedge clock);
      check("cmp porb_l", porb_l, int'(hi_run >= FC));
      check("cmp rstb_core", rstb_core, int'(hi_run >= FC + SD));
      check("cmp rstb_user", rstb_user, int'(user_rel));
      check("cmp por_fault", por_fault, int'(fault_m));
      check("cmp seq_state", seq_state, exp_state());
   end

   function automatic logic sig(input int sel);
      case (sel)
         0:       return porb_l;
         1:       return rstb_core;
         2:       return rstb_user;
         default: return por_fault;
      endcase
   endfunction

   // Counts rising edges until the selected output reaches lvl; n starts at 'start'.
   task automatic wait_level(input int sel, input logic lvl, input int start, output int n);
      bit found = 1'b0;
      n = start;
      for (int i = 0; i < 400 && !found; i++) begin
         @(posedge clock);
         #1;
         n++;
         if (sig(sel) === lvl) found = 1'b1;
      end
      if (!found) begin
         tests++;
         fails++;
         $display("FAIL wait timeout: output %0d never reached %0d", sel, lvl);
      end
   endtask

   int n;
   int out_max;
   bit saw_filter, bad_state;

   initial begin
      // Reset state
      #12;
      check("reset porb_l", porb_l, 0);
      check("reset rstb_core", rstb_core, 0);
      check("reset rstb_user", rstb_user, 0);
      check("reset seq_state", seq_state, 0);
      @(negedge clock);
      resetb = 1'b1;
      repeat (3) @(negedge clock);

      // Nominal release with cfg_done already high
      cfg_done = 1'b1;
      por_yl   = 1'b1;
      wait_level(0, 1'b1, -1, n); check("A porb_l latency", n, 17);
      wait_level(1, 1'b1, 0, n);  check("A rstb_core delay", n, 8);
      wait_level(2, 1'b1, 0, n);  check("A rstb_user delay", n, 1);
      check("A por_fault", por_fault, 0);
      check("A seq_state run", seq_state, 4);

      // Short glitches never get past FILTER
      @(negedge clock);
      por_yl = 1'b0;
      repeat (5) @(negedge clock);
      out_max = 0; saw_filter = 1'b0; bad_state = 1'b0;
      for (int p = 0; p < 5; p++) begin
         por_yl = 1'b1;
         for (int c = 0; c < 20; c++) begin
            if (c == 10) por_yl = 1'b0;
            @(negedge clock);
            if (porb_l | rstb_core | rstb_user) out_max = 1;
            if (seq_state == 3'd1) saw_filter = 1'b1;
            if (seq_state > 3'd1) bad_state = 1'b1;
         end
      end
      check("B outputs stayed low", out_max, 0);
      check("B reached FILTER", saw_filter, 1);
      check("B state only 0/1", bad_state, 0);

      // Ack timeout
      cfg_done = 1'b0;
      por_yl   = 1'b1;
      wait_level(0, 1'b1, -1, n); check("C porb_l latency", n, 17);
      wait_level(1, 1'b1, 0, n);  check("C rstb_core delay", n, 8);
      wait_level(2, 1'b1, 0, n);  check("C timeout delay", n, 200);
      check("C por_fault same edge", por_fault, 1);
      @(negedge clock); cfg_done = 1'b1;
      @(negedge clock); cfg_done = 1'b0;
      @(negedge clock);
      check("C late ack state", seq_state, 4);
      check("C late ack fault", por_fault, 1);

      // One-cycle brownout in RUN
      por_yl = 1'b0;
      @(negedge clock);
      por_yl = 1'b1;
      wait_level(0, 1'b0, 1, n); check("D fall latency", n, 3);
      check("D rstb_core low", rstb_core, 0);
      check("D rstb_user low", rstb_user, 0);
      check("D fault kept", por_fault, 1);
      wait_level(0, 1'b1, 0, n); check("D replay porb_l", n, 16);
      wait_level(1, 1'b1, 0, n); check("D replay rstb_core", n, 8);
      wait_level(2, 1'b1, 0, n); check("D replay rstb_user", n, 200);

      // Synchronized power loss coincides with cfg_done in WAIT_ACK
      @(negedge clock);
      por_yl = 1'b0;
      wait_level(0, 1'b0, 0, n);
      @(negedge clock);
      por_yl = 1'b1;
      wait_level(1, 1'b1, -100, n);
      @(negedge clock);
      check("E in WAIT_ACK", seq_state, 3);
      por_yl = 1'b0;
      @(negedge clock);
      @(negedge clock);
      cfg_done = 1'b1;
      out_max = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clock);
         if (rstb_user) out_max = 1;
         if (c == 0) check("E state HOLD", seq_state, 0);
      end
      check("E rstb_user never high", out_max, 0);

      // Asynchronous reset in CORE_REL restarts the whole sequence
      por_yl = 1'b1;
      wait_level(0, 1'b1, -1, n);
      repeat (3) @(posedge clock);
      #2 resetb = 1'b0;
      #1;
      check("F async porb_l", porb_l, 0);
      check("F async rstb_core", rstb_core, 0);
      check("F async seq_state", seq_state, 0);
      check("F async fault", por_fault, 0);
      @(negedge clock);
      resetb = 1'b1;
      wait_level(0, 1'b1, -1, n); check("F restart porb_l", n, 17);
      wait_level(1, 1'b1, 0, n);  check("F restart rstb_core", n, 8);
      wait_level(2, 1'b1, 0, n);  check("F restart rstb_user", n, 1);
      @(negedge clock);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
